// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: picks a mole from an LFSR, arms the external timer and scores hits/misses.
// Optional MISS_PENALTY_EN: a wrong-index hit in UP costs a point and ends the round as a miss.
module mole_round_ctrl #(
  parameter int          NUM_MOLES  = 8,
  parameter int          IDX_W      = 3,
  parameter int          NUM_ROUNDS = 10,
  parameter int          SCORE_W    = 8,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hit_valid,
  input  logic [IDX_W-1:0]     hit_idx,
  output logic                 timer_load,
  input  logic                 timer_running,
  input  logic                 timer_timeout,
  output logic [NUM_MOLES-1:0] mole_onehot,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic [7:0]           round_cnt,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_RUN, S_UP, S_NEXT, S_DONE
  } state_t;

  state_t               r_state;
  logic [7:0]           r_lfsr;
  logic [IDX_W-1:0]     r_cur_idx;
  logic [1:0]           r_wd_cnt;
  logic                 r_timer_load;
  logic [NUM_MOLES-1:0] r_mole;
  logic [SCORE_W-1:0]   r_score;
  logic [SCORE_W-1:0]   r_misses;
  logic [7:0]           r_round_cnt;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_lfsr_fb;
  logic                 w_hit_ok;
  logic [SCORE_W-1:0]   w_score_inc;
  logic [SCORE_W-1:0]   w_misses_inc;
  logic [7:0]           w_round_nxt;
  logic                 w_last_round;
  logic [NUM_MOLES-1:0] w_mole_dec;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_hit_ok     = hit_valid && (hit_idx == r_cur_idx);
  assign w_score_inc  = (&r_score)  ? r_score  : r_score  + SCORE_W'(1);
  assign w_misses_inc = (&r_misses) ? r_misses : r_misses + SCORE_W'(1);
  assign w_round_nxt  = r_round_cnt + 8'd1;
  assign w_last_round = (w_round_nxt == 8'(NUM_ROUNDS));
  assign w_mole_dec   = NUM_MOLES'(1) << r_cur_idx;

`ifdef MISS_PENALTY_EN
  logic               w_hit_bad;
  logic [SCORE_W-1:0] w_score_dec;
  assign w_hit_bad   = hit_valid && (hit_idx != r_cur_idx);
  assign w_score_dec = (r_score == '0) ? r_score : r_score - SCORE_W'(1);
`endif

  always_ff @(posedge clk) begin
    // NOTE: every register here, including the LFSR and mole index, is cleared by rst so an aborted round leaves no residue.
    if (rst) begin
      r_state      <= S_IDLE;
      r_lfsr       <= LFSR_SEED;
      r_cur_idx    <= '0;
      r_wd_cnt     <= '0;
      r_timer_load <= 1'b0;
      r_mole       <= '0;
      r_score      <= '0;
      r_misses     <= '0;
      r_round_cnt  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_lfsr       <= {r_lfsr[6:0], w_lfsr_fb};
      // NOTE: non-blocking default makes timer_load a single-cycle pulse; only entries into ARM raise it.
      r_timer_load <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_ARM;
            r_timer_load <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_score      <= '0;
            r_misses     <= '0;
            r_round_cnt  <= '0;
          end
        end
        S_ARM: begin
          r_cur_idx <= r_lfsr[IDX_W-1:0];
          r_wd_cnt  <= '0;
          r_state   <= S_WAIT_RUN;
        end
        S_WAIT_RUN: begin
          // timeout is stale from the last round here, so only running matters
          if (timer_running) begin
            r_state <= S_UP;
            r_mole  <= w_mole_dec;
          end else if (r_wd_cnt == 2'd3) begin
            r_state      <= S_ARM;
            r_timer_load <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt + 2'd1;
          end
        end
        S_UP: begin
          if (w_hit_ok) begin
            r_score <= w_score_inc;
            r_mole  <= '0;
            r_state <= S_NEXT;
          end
`ifdef MISS_PENALTY_EN
          else if (w_hit_bad) begin
            r_score  <= w_score_dec;
            r_misses <= w_misses_inc;
            r_mole   <= '0;
            r_state  <= S_NEXT;
          end
`endif
          else if (timer_timeout) begin
            r_misses <= w_misses_inc;
            r_mole   <= '0;
            r_state  <= S_NEXT;
          end
        end
        S_NEXT: begin
          r_round_cnt <= w_round_nxt;
          if (w_last_round) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state      <= S_ARM;
            r_timer_load <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_mole  <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign timer_load  = r_timer_load;
  assign mole_onehot = r_mole;
  assign score       = r_score;
  assign misses      = r_misses;
  assign round_cnt   = r_round_cnt;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench for mole_round_ctrl with a 20-tick timer model and a stub timer for watchdog/stale-timeout cases.
`timescale 1ns/1ps
module tb_mole_round_ctrl;

  localparam int NUM_ROUNDS = 3;
  localparam int WINDOW     = 20;

  logic       clk = 1'b0;
  logic       rst, start, hit_valid;
  logic [2:0] hit_idx;
  logic       timer_load, timer_running, timer_timeout;
  logic [7:0] mole_onehot, score, misses, round_cnt;
  logic       busy, done;

  logic       use_model, stub_run, stub_to;
  logic       m_run, m_to;
  int         m_cnt;
  logic [7:0] m_lfsr;
  logic [2:0] exp_idx;
  int         checks = 0;
  int         failures = 0;
  int         load_cnt = 0;
  int         load_mark;

  always #5 clk = ~clk;

  mole_round_ctrl #(
    .NUM_MOLES(8), .IDX_W(3), .NUM_ROUNDS(NUM_ROUNDS), .SCORE_W(8), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hit_valid(hit_valid), .hit_idx(hit_idx),
    .timer_load(timer_load), .timer_running(timer_running), .timer_timeout(timer_timeout),
    .mole_onehot(mole_onehot), .score(score), .misses(misses), .round_cnt(round_cnt),
    .busy(busy), .done(done)
  );

  assign timer_running = use_model ? m_run : stub_run;
  assign timer_timeout = use_model ? m_to  : stub_to;

  // Timer model: CLOCK_FREQ=10, INIT_SEC=2 -> 20-tick window, sticky timeout until next load
  always @(posedge clk) begin
    if (rst) begin
      m_run <= 1'b0; m_to <= 1'b0; m_cnt <= 0;
    end else if (timer_load) begin
      m_run <= 1'b1; m_to <= 1'b0; m_cnt <= WINDOW;
    end else if (m_run) begin
      if (m_cnt == 1) begin
        m_run <= 1'b0; m_to <= 1'b1;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, advancing every non-reset clock
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (timer_load === 1'b1) load_cnt++;
  endtask

  task automatic wait_mole_up(input string tag);
    int n = 0;
    while (mole_onehot === 8'd0 && n < 40) begin tick(); n++; end
    check(tag, 32'(mole_onehot !== 8'd0), 32'd1);
  endtask

  task automatic wait_mole_down(input string tag);
    int n = 0;
    while (mole_onehot !== 8'd0 && n < 40) begin tick(); n++; end
    check(tag, 32'(mole_onehot === 8'd0), 32'd1);
  endtask

  task automatic pulse_hit(input logic [2:0] idx);
    hit_valid = 1'b1; hit_idx = idx;
    tick();
    hit_valid = 1'b0; hit_idx = 3'd0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hit_valid = 1'b0; hit_idx = 3'd0;
    use_model = 1'b1; stub_run = 1'b0; stub_to = 1'b0;

    // Reset and idle
    tick(); tick();
    check("rst_score", 32'(score), 32'd0);
    check("rst_misses", 32'(misses), 32'd0);
    check("rst_round", 32'(round_cnt), 32'd0);
    check("rst_mole", 32'(mole_onehot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_load", 32'(timer_load), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("idle_no_load", 32'(load_cnt), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Game 1, round 1: single correct hit with the timer model
    start = 1'b1;
    tick();
    start = 1'b0;
    check("g1_start_load", 32'(timer_load), 32'd1);
    check("g1_busy", 32'(busy), 32'd1);
    exp_idx = m_lfsr[2:0];
    tick();
    check("g1_load_width", 32'(timer_load), 32'd0);
    wait_mole_up("g1r1_mole_wait");
    check("g1r1_mole", 32'(mole_onehot), 32'(8'd1 << exp_idx));
    start = 1'b1;  // start while busy must be ignored
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    pulse_hit(exp_idx);
    check("g1r1_mole_clear", 32'(mole_onehot), 32'd0);
    check("g1r1_score", 32'(score), 32'd1);
    check("g1r1_misses", 32'(misses), 32'd0);
    check("g1r1_one_load", 32'(load_cnt), 32'd1);
    tick();
    check("g1r1_round", 32'(round_cnt), 32'd1);
    check("g1r2_load", 32'(timer_load), 32'd1);
    exp_idx = m_lfsr[2:0];

    // Round 2: no hit, the window times out
    wait_mole_up("g1r2_mole_wait");
    check("g1r2_mole", 32'(mole_onehot), 32'(8'd1 << exp_idx));
    wait_mole_down("g1r2_timeout_wait");
    check("g1r2_misses", 32'(misses), 32'd1);
    check("g1r2_score", 32'(score), 32'd1);
    tick();
    check("g1r3_load", 32'(timer_load), 32'd1);
    check("g1r3_round", 32'(round_cnt), 32'd2);
    exp_idx = m_lfsr[2:0];

    // Round 3: stale timeout must not score a miss; then hit and timeout coincide
    wait_mole_up("g1r3_mole_wait");
    check("g1r3_mole", 32'(mole_onehot), 32'(8'd1 << exp_idx));
    check("g1r3_no_stale_miss", 32'(misses), 32'd1);
    begin
      int n = 0;
      while (timer_timeout !== 1'b1 && n < 40) begin tick(); n++; end
    end
    check("g1r3_still_up", 32'(mole_onehot), 32'(8'd1 << exp_idx));
    pulse_hit(exp_idx);
    check("g1r3_hit_wins_score", 32'(score), 32'd2);
    check("g1r3_hit_wins_misses", 32'(misses), 32'd1);
    tick();
    check("g1_done", 32'(done), 32'd1);
    check("g1_busy_low", 32'(busy), 32'd0);
    check("g1_rounds", 32'(round_cnt), 32'd3);

    // Game 2: restart from DONE, every round times out
    load_mark = load_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("g2_clr_score", 32'(score), 32'd0);
    check("g2_clr_misses", 32'(misses), 32'd0);
    check("g2_clr_round", 32'(round_cnt), 32'd0);
    check("g2_done_low", 32'(done), 32'd0);
    begin
      int n = 0;
      while (done !== 1'b1 && n < 200) begin tick(); n++; end
    end
    check("g2_done", 32'(done), 32'd1);
    check("g2_misses", 32'(misses), 32'd3);
    check("g2_score", 32'(score), 32'd0);
    check("g2_busy", 32'(busy), 32'd0);
    check("g2_loads", 32'(load_cnt - load_mark), 32'd3);
    tick(); tick();
    check("g2_hold_misses", 32'(misses), 32'd3);

    // Game 3: stub timer never runs -> watchdog re-issues load every 5 cycles
    use_model = 1'b0; stub_run = 1'b0; stub_to = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("g3_load0", 32'(timer_load), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("wd_load_k%0d", k), 32'(timer_load), 32'((k % 5) == 0));
    end
    check("wd_round", 32'(round_cnt), 32'd0);
    check("wd_misses", 32'(misses), 32'd0);
    check("wd_busy", 32'(busy), 32'd1);
    exp_idx = m_lfsr[2:0];
    stub_run = 1'b1; stub_to = 1'b0;
    wait_mole_up("g3r1_mole_wait");
    check("g3r1_mole", 32'(mole_onehot), 32'(8'd1 << exp_idx));
    pulse_hit(exp_idx);
    check("g3r1_score", 32'(score), 32'd1);
    tick();
    check("g3r2_load", 32'(timer_load), 32'd1);
    exp_idx = m_lfsr[2:0];
    wait_mole_up("g3r2_mole_wait");
    check("g3r2_mole", 32'(mole_onehot), 32'(8'd1 << exp_idx));
    pulse_hit(exp_idx ^ 3'd1);
`ifdef MISS_PENALTY_EN
    check("pen_score", 32'(score), 32'd0);
    check("pen_misses", 32'(misses), 32'd1);
    check("pen_mole", 32'(mole_onehot), 32'd0);
`else
    check("wrong_hit_mole", 32'(mole_onehot), 32'(8'd1 << exp_idx));
    check("wrong_hit_score", 32'(score), 32'd1);
    check("wrong_hit_misses", 32'(misses), 32'd0);
`endif
    wait_mole_up("g3_up_before_rst");

    // Mid-round reset
    rst = 1'b1;
    tick();
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_score", 32'(score), 32'd0);
    check("mrst_misses", 32'(misses), 32'd0);
    check("mrst_round", 32'(round_cnt), 32'd0);
    check("mrst_mole", 32'(mole_onehot), 32'd0);
    check("mrst_load", 32'(timer_load), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    load_mark = load_cnt;
    for (int i = 0; i < 4; i++) tick();
    check("post_rst_no_load", 32'(load_cnt - load_mark), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
